// File: rtl/clock_tune_ctl.sv
// Delay-line tap controller: counts oscillator edges over a window of clk cycles,
// compares the count with target +/- tol and steps a one-hot tap enable (linear or binary search).
module clock_tune_ctl #(
  parameter int NTAPS    = 512,
  parameter int IDX_W    = 9,
  parameter int CNT_W    = 32,
  parameter int INIT_TAP = 510,
  parameter int SETTLE   = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] window,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] tol,
  input  logic             osc_edge,
  output logic [NTAPS-1:0] en,
  output logic [IDX_W-1:0] tap,
  output logic [CNT_W-1:0] meas,
  output logic             meas_valid,
  output logic             lock,
  output logic             sat_lo,
  output logic             sat_hi,
  output logic [1:0]       state_dbg
);

  // Handshake: meas_valid is a one-cycle strobe with no back-pressure; meas is
  // stable while it is high, and tap/en/lock/sat_* update on the edge that ends it.

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL} state_t;

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_CNT);
  localparam logic [IDX_W-1:0] TAP_MAX  = IDX_W'(NTAPS - 1);
  localparam logic [IDX_W-1:0] TAP_MID  = IDX_W'((NTAPS - 1) / 2);
  localparam logic [IDX_W-1:0] TAP_INIT = IDX_W'(INIT_TAP);
  localparam logic [IDX_W:0]   HI_INIT  = (IDX_W+1)'(NTAPS - 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_inc;
  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] meas_q;
  logic             meas_valid_q;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic [IDX_W:0]   lo_q, lo_d, hi_q, hi_d;
  logic             bin_q, bin_d;
  logic             lock_q, lock_d;
  logic             sat_lo_q, sat_lo_d, sat_hi_q, sat_hi_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             last_in_q;
  logic [CNT_W:0]   hi_bound, lo_bound, meas_x;
  logic             fast, slow, in_band;
  logic [IDX_W:0]   lo_t, hi_t;

  assign win_last = (window == '0) ? '0 : window - CNT_W'(1);
  assign edge_inc = (osc_edge && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable) state_d = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SET_LAST) state_d = S_MEASURE;
      S_MEASURE: if (win_cnt == win_last) state_d = S_EVAL;
      S_EVAL:    state_d = S_SETTLE;
      default:   state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Band compare is one bit wider so target+tol cannot wrap.
  assign hi_bound = {1'b0, target} + {1'b0, tol};
  assign lo_bound = (tol > target) ? '0 : {1'b0, target - tol};
  assign meas_x   = {1'b0, meas_q};
  assign fast     = meas_x > hi_bound;
  assign slow     = meas_x < lo_bound;
  assign in_band  = !fast && !slow;

  always_comb begin
    tap_d    = tap_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    bin_d    = bin_q;
    sat_lo_d = 1'b0;
    sat_hi_d = 1'b0;
    lo_t     = lo_q;
    hi_t     = hi_q;
    if (bin_q) begin
      if (in_band) begin
        bin_d = 1'b0;
      end else begin
        if (fast) lo_t = {1'b0, tap_q} + (IDX_W+1)'(1);
        else      hi_t = (tap_q == '0) ? '0 : {1'b0, tap_q} - (IDX_W+1)'(1);
        lo_d = lo_t;
        hi_d = hi_t;
        if (lo_t >= hi_t) begin
          tap_d = (lo_t > {1'b0, TAP_MAX}) ? TAP_MAX : lo_t[IDX_W-1:0];
          bin_d = 1'b0;
        end else begin
          tap_d = IDX_W'((lo_t + hi_t) >> 1);
        end
      end
    end else if (fast) begin
      if (tap_q == TAP_MAX) sat_hi_d = 1'b1;
      else                  tap_d = tap_q + IDX_W'(1);
    end else if (slow) begin
      if (tap_q == '0) sat_lo_d = 1'b1;
      else             tap_d = tap_q - IDX_W'(1);
    end
  end

  // Run counter restarts at 1 whenever the in-band verdict flips.
  always_comb begin
    if ((run_q == '0) || (in_band != last_in_q)) run_d = RUN_W'(1);
    else if (run_q == RUN_MAX)                    run_d = run_q;
    else                                          run_d = run_q + RUN_W'(1);
    lock_d = lock_q;
    if (run_d >= RUN_MAX) lock_d = in_band;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      settle_cnt   <= '0;
      win_cnt      <= '0;
      edge_cnt     <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      tap_q        <= TAP_INIT;
      lo_q         <= '0;
      hi_q         <= '0;
      bin_q        <= 1'b0;
      lock_q       <= 1'b0;
      sat_lo_q     <= 1'b0;
      sat_hi_q     <= 1'b0;
      run_q        <= '0;
      last_in_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      meas_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          settle_cnt <= '0;
          if (enable) begin
            bin_q <= mode;
            if (mode) begin
              tap_q <= TAP_MID;
              lo_q  <= '0;
              hi_q  <= HI_INIT;
            end
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
          win_cnt    <= '0;
          edge_cnt   <= '0;
        end
        S_MEASURE: begin
          win_cnt  <= win_cnt + CNT_W'(1);
          edge_cnt <= edge_inc;
          if (state_d == S_EVAL) begin
            meas_q       <= edge_inc;
            meas_valid_q <= 1'b1;
          end
        end
        S_EVAL: begin
          settle_cnt <= '0;
          if (enable) begin
            tap_q     <= tap_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            bin_q     <= bin_d;
            sat_lo_q  <= sat_lo_d;
            sat_hi_q  <= sat_hi_d;
            run_q     <= run_d;
            last_in_q <= in_band;
            lock_q    <= lock_d;
          end
        end
        default: ;
      endcase
      if (!enable) begin
        lock_q <= 1'b0;
        run_q  <= '0;
      end
    end
  end

  assign en         = NTAPS'(1) << tap_q;
  assign tap        = tap_q;
  assign meas       = meas_q;
  assign meas_valid = meas_valid_q;
  assign lock       = lock_q;
  assign sat_lo     = sat_lo_q;
  assign sat_hi     = sat_hi_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_clock_tune_ctl.sv
// Bench for clock_tune_ctl: a 512-tap and a 16-tap instance share stimulus; one is
// observed at a time against a behavioural model of the tuning loop.
module tb_clock_tune_ctl;
  localparam int SET    = 8;
  localparam int LCK    = 4;
  localparam int NT_A   = 512;
  localparam int NT_B   = 16;
  localparam int INIT_A = 510;
  localparam int INIT_B = 3;

  logic clk = 1'b0;
  logic reset, enable, mode, osc;
  logic [31:0] window, target, tol;

  logic [NT_A-1:0] en_a;
  logic [8:0]      tap_a;
  logic [31:0]     meas_a;
  logic            mv_a, lock_a, slo_a, shi_a;
  logic [1:0]      st_a;
  logic [NT_B-1:0] en_b;
  logic [3:0]      tap_b;
  logic [31:0]     meas_b;
  logic            mv_b, lock_b, slo_b, shi_b;
  logic [1:0]      st_b;

  clock_tune_ctl #(.NTAPS(NT_A), .IDX_W(9), .CNT_W(32), .INIT_TAP(INIT_A), .SETTLE(SET), .LOCK_CNT(LCK)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .window(window), .target(target),
    .tol(tol), .osc_edge(osc), .en(en_a), .tap(tap_a), .meas(meas_a), .meas_valid(mv_a),
    .lock(lock_a), .sat_lo(slo_a), .sat_hi(shi_a), .state_dbg(st_a));

  clock_tune_ctl #(.NTAPS(NT_B), .IDX_W(4), .CNT_W(32), .INIT_TAP(INIT_B), .SETTLE(SET), .LOCK_CNT(LCK)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .window(window), .target(target),
    .tol(tol), .osc_edge(osc), .en(en_b), .tap(tap_b), .meas(meas_b), .meas_valid(mv_b),
    .lock(lock_b), .sat_lo(slo_b), .sat_hi(shi_b), .state_dbg(st_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int sel = 0;

  // Behavioural model of the tuning loop
  int m_tap, m_lock, m_slo, m_shi, m_run, m_last, m_bin, m_lo, m_hi, m_nt;
  longint m_meas;

  logic [63:0] o_tap, o_meas;
  logic o_mv, o_lock, o_slo, o_shi;
  always_comb begin
    o_tap  = (sel != 0) ? 64'(tap_b)  : 64'(tap_a);
    o_meas = (sel != 0) ? 64'(meas_b) : 64'(meas_a);
    o_mv   = (sel != 0) ? mv_b   : mv_a;
    o_lock = (sel != 0) ? lock_b : lock_a;
    o_slo  = (sel != 0) ? slo_b  : slo_a;
    o_shi  = (sel != 0) ? shi_b  : shi_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_nt   = (sel != 0) ? NT_B : NT_A;
    m_tap  = (sel != 0) ? INIT_B : INIT_A;
    m_lock = 0; m_slo = 0; m_shi = 0; m_run = 0; m_last = 0; m_bin = 0;
    m_lo   = 0; m_hi = 0; m_meas = 0;
  endtask

  task automatic model_start(input int md);
    m_bin = md;
    if (md != 0) begin
      m_lo  = 0;
      m_hi  = m_nt - 1;
      m_tap = (m_nt - 1) / 2;
    end
  endtask

  task automatic model_eval(input longint c);
    longint hb, lb;
    int fast, slow, inb;
    hb = longint'(target) + longint'(tol);
    lb = longint'(target) - longint'(tol);
    if (lb < 0) lb = 0;
    fast = (c > hb) ? 1 : 0;
    slow = (c < lb) ? 1 : 0;
    inb  = (fast == 0 && slow == 0) ? 1 : 0;
    m_slo = 0;
    m_shi = 0;
    if (m_bin != 0) begin
      if (inb != 0) m_bin = 0;
      else begin
        if (fast != 0) m_lo = m_tap + 1;
        else           m_hi = (m_tap == 0) ? 0 : m_tap - 1;
        if (m_lo >= m_hi) begin
          m_tap = (m_lo > m_nt - 1) ? m_nt - 1 : m_lo;
          m_bin = 0;
        end else m_tap = (m_lo + m_hi) / 2;
      end
    end else if (fast != 0) begin
      if (m_tap == m_nt - 1) m_shi = 1; else m_tap++;
    end else if (slow != 0) begin
      if (m_tap == 0) m_slo = 1; else m_tap--;
    end
    if (m_run == 0 || inb != m_last) m_run = 1;
    else if (m_run < LCK) m_run++;
    m_last = inb;
    if (m_run >= LCK) m_lock = inb;
  endtask

  task automatic check_outputs(input string tag);
    logic [NT_A-1:0] ea;
    logic [NT_B-1:0] eb;
    ea = '0;
    eb = '0;
    if (sel != 0) eb[m_tap] = 1'b1; else ea[m_tap] = 1'b1;
    chk({tag, "_tap"}, o_tap, 64'(m_tap));
    chk({tag, "_en"}, (sel != 0) ? 64'(en_b == eb) : 64'(en_a == ea), 64'd1);
    chk({tag, "_lock"}, 64'(o_lock), 64'(m_lock));
    chk({tag, "_sat_lo"}, 64'(o_slo), 64'(m_slo));
    chk({tag, "_sat_hi"}, 64'(o_shi), 64'(m_shi));
    chk({tag, "_mv_low"}, 64'(o_mv), 64'd0);
    chk({tag, "_meas"}, o_meas, 64'(m_meas));
  endtask

  task automatic do_reset();
    enable = 1'b0;
    osc    = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start(input int md);
    enable = 1'b1;
    mode   = 1'(md);
    model_start(md);
    tick();
  endtask

  function automatic logic pat_bit(input int pat, input int j, input int n);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (j % 2 == 0);
      3:       return (j < n);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One full iteration starting in the first SETTLE cycle; osc noise outside MEASURE must be ignored.
  task automatic run_iter(input string tag, input int pat, input int n);
    int weff;
    longint cnt;
    weff = (window == 0) ? 1 : int'(window);
    cnt  = 0;
    for (int i = 0; i < SET; i++) begin
      osc = 1'($urandom_range(0, 1));
      tick();
      if (i == 0) chk({tag, "_settle_mv"}, 64'(o_mv), 64'd0);
    end
    for (int j = 0; j < weff; j++) begin
      osc = pat_bit(pat, j, n);
      if (osc) cnt++;
      tick();
    end
    osc = 1'($urandom_range(0, 1));
    chk({tag, "_eval_mv"}, 64'(o_mv), 64'd1);
    chk({tag, "_eval_meas"}, o_meas, 64'(cnt));
    m_meas = cnt;
    model_eval(cnt);
    tick();
    osc = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    int bseq[4];
    bseq = '{11, 9, 10, 10};
    reset = 1'b1; enable = 1'b0; mode = 1'b0; osc = 1'b0;
    window = 32'd100; target = 32'd50; tol = 32'd2;

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      check_outputs("reset");
    end

    // Lock set, then lock clear with linear saturation at the top tap
    sel = 0;
    do_reset();
    window = 32'd100; target = 32'd50; tol = 32'd2;
    start(0);
    for (int k = 0; k < 4; k++) run_iter("lock_set", 2, 0);
    chk("lock_after_4", 64'(lock_a), 64'd1);
    for (int k = 0; k < 4; k++) run_iter("lock_clear", 1, 0);
    chk("sat_hi_at_top", 64'(shi_a), 64'd1);
    chk("tap_at_top", 64'(tap_a), 64'd511);

    // Bounds: no wrap on target+tol, floored target-tol, zero window
    do_reset();
    window = 32'd10; target = 32'hFFFF_FFFF; tol = 32'd2;
    start(0);
    run_iter("bound_hi_nowrap", 1, 0);
    target = 32'd1; tol = 32'd5;
    run_iter("bound_lo_floor", 0, 0);
    window = 32'd0;
    run_iter("window_zero", 4, 0);

    // Lock up, then abort mid-MEASURE
    window = 32'd20; target = 32'd10; tol = 32'd0;
    for (int k = 0; k < 4; k++) run_iter("relock", 2, 0);
    for (int i = 0; i < SET + 7; i++) begin
      osc = 1'($urandom_range(0, 1));
      tick();
    end
    enable = 1'b0;
    tick();
    m_lock = 0;
    m_run  = 0;
    check_outputs("abort");
    for (int i = 0; i < 25; i++) begin
      osc = 1'($urandom_range(0, 1));
      tick();
      if (o_mv !== 1'b0) chk("abort_idle_mv", 64'(o_mv), 64'd0);
    end
    check_outputs("abort_idle");

    // Reset pulse mid-SETTLE
    start(0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    check_outputs("reset_mid_settle");
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // Binary search acquisition on the 16-tap instance
    sel = 1;
    do_reset();
    window = 32'd64; target = 32'd24; tol = 32'd1;
    start(1);
    chk("bin_start_tap", 64'(tap_b), 64'd7);
    for (int k = 0; k < 4; k++) begin
      run_iter("bin", 3, 64 - 4 * m_tap);
      chk("bin_seq", 64'(tap_b), 64'(bseq[k]));
    end
    for (int k = 0; k < LCK; k++) run_iter("bin_track", 3, 64 - 4 * m_tap);
    chk("bin_locked", 64'(lock_b), 64'd1);

    // Randomised rounds on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      for (int r = 0; r < 3; r++) begin
        window = 32'($urandom_range(0, 12));
        target = 32'($urandom_range(0, 8));
        tol    = 32'($urandom_range(0, 2));
        start(int'($urandom_range(0, 1)));
        for (int k = 0; k < 6; k++) run_iter("rand", 4, 0);
        enable = 1'b0;
        tick();
        m_lock = 0;
        m_run  = 0;
        tick();
        check_outputs("rand_stop");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_tune_ctl.md
# clock_tune_ctl

Parametrised single-clock successor to the delay-line tap controller. It counts pre-synchronised oscillator edge pulses over a programmable window of `clk` cycles and compares the count against a target with a tolerance band. It then moves a one-hot tap-enable vector, using either linear stepping or binary-search acquisition followed by linear tracking. It sits between the tunable delay line, which consumes `en`, and the configuration/status register block.

## Interface
- `NTAPS`, 512, number of delay taps (≥2)
- `IDX_W`, 9, tap index width, ≥ clog2(NTAPS)
- `CNT_W`, 32, width of window/target/tol/measurement
- `INIT_TAP`, 510, tap selected after reset
- `SETTLE`, 8, idle cycles after every tap change before measuring (≥1)
- `LOCK_CNT`, 4, consecutive in-band/out-of-band evaluations to set/clear lock (≥1)

- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `enable` in 1 — run tuning loop
- `mode` in 1 — 0 linear, 1 binary search then linear; sampled on leaving IDLE
- `window` in CNT_W — measurement length in clk cycles; 0 treated as 1
- `target` in CNT_W — desired edge count per window
- `tol` in CNT_W — allowed deviation
- `osc_edge` in 1 — one-cycle pulse per oscillator edge, already in clk domain
- `en` out NTAPS — one-hot tap enable, `en == 1 << tap`
- `tap` out IDX_W — current tap index
- `meas` out CNT_W — last measured count
- `meas_valid` out 1 — one-cycle pulse when `meas` updates
- `lock` out 1 — loop locked
- `sat_lo` / `sat_hi` out 1 — last correction was blocked at tap 0 / NTAPS-1

## Operation
- Reset values: `tap=INIT_TAP`, `en=1<<INIT_TAP`, `meas=0`, `meas_valid=0`, `lock=0`, `sat_lo=sat_hi=0`, state IDLE, edge and window counters 0.
- States: IDLE, SETTLE, MEASURE, EVAL.
- IDLE: enable=1 → SETTLE. In mode 1, set lo=0, hi=NTAPS-1, tap=(NTAPS-1)>>1 on this transition. Mode 0 keeps the current tap.
- SETTLE: SETTLE cycles, then MEASURE.
- MEASURE: exactly max(window,1) cycles. Each cycle with `osc_edge=1` increments the count. The count saturates at all-ones.
- EVAL: one cycle. `meas<=count`, `meas_valid` pulses, then → SETTLE.
- Band compare uses CNT_W+1 bits. hi_bound=target+tol with no wrap. lo_bound=target−tol, floored at 0.
- count>hi_bound: "fast", tap must increase. count<lo_bound: "slow", tap must decrease. Otherwise "in-band", tap held.
- Linear correction: tap ±1. If the move is blocked at the end, the tap holds and `sat_hi`/`sat_lo` is set; otherwise both are cleared. Flags update every EVAL.
- Binary correction:
  - fast → lo=tap+1; slow → hi=tap−1, where hi=0 if tap=0.
  - New tap=(lo+hi)>>1.
  - If lo≥hi, tap=clamp(lo) and switch to linear.
  - In-band → switch to linear.
- Lock hysteresis:
  - Sets after LOCK_CNT consecutive in-band EVALs.
  - Clears after LOCK_CNT consecutive non-in-band EVALs.
  - The run counter resets when the band result changes.
- enable=0 in any state → IDLE next cycle. The current measurement is discarded with no `meas_valid`. The tap is held, `lock` clears, and run counters clear.
- reset during any state restores all reset values on the next edge.

## Timing
- Iteration period = SETTLE + max(window,1) + 1 cycles.
- `osc_edge` is counted only in MEASURE cycles. Pulses in SETTLE or EVAL are ignored.
- `tap`, `en`, `sat_*` and `lock` update on the edge ending EVAL. They are visible in the same cycle `meas_valid` is seen low again.
- `en` and `tap` change together. `en` is never zero and never multi-hot.
- First EVAL after enable rises: cycle 1+SETTLE+window.

## Test plan
- Reset: assert reset 2 cycles → `tap=510`, `en=1<<510`, `lock=0`, `meas=0`, `meas_valid=0`.
- Linear saturation: mode0, window=100, target=50, tol=2, osc_edge every cycle → `meas=100`, tap 510→511; next EVAL holds at 511 with `sat_hi=1`.
- Lock: mode0, window=100, target=50, tol=2, osc_edge every 2nd cycle → meas=50 each EVAL, tap unchanged, `lock=1` after 4th EVAL; switch to continuous pulses → lock clears after 4 more EVALs.
- Binary search: NTAPS=16, IDX_W=4, window=64, target=24, tol=1, bench returns count=64−4·tap → taps 7,11,9,10, then in-band at 10, linear; lock after LOCK_CNT further in-band EVALs.
- Bounds: target=0xFFFFFFFF, tol=2, count 0xFFFFFFFF → in-band with no wrap; target=1, tol=5, count 0 → in-band; window=0 → 1-cycle measurement.
- Abort: drop enable mid-MEASURE → IDLE next cycle, no `meas_valid`, tap held, `lock=0`; pulse reset mid-SETTLE → full reset values.
